// File: rtl/matmul_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matmul_pkg : shared types and constants for the sequential matrix multiplier
// Rev 1.0    : initial release
// ----------------------------------------------------------------------------
package matmul_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_CALC  = 2'd2,
      ST_STORE = 2'd3
   } state_t;

   localparam int c_def_elem_w = 4;
   localparam int c_def_dim    = 4;

   // Wide enough for DIM full-scale products, so the accumulator never wraps.
   function automatic int acc_width(input int elem_w, input int dim);
      return 2 * elem_w + $clog2(dim);
   endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_seq_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matmul_seq_unit_if : start/busy/done handshake and operand/result bus
// Rev 1.0            : initial release
// ----------------------------------------------------------------------------
interface matmul_seq_unit_if
   import matmul_pkg::*;
#(
   parameter int ELEM_W = c_def_elem_w,
   parameter int DIM    = c_def_dim
);
   logic                       start;
   logic                       sat_mode;
   logic [DIM*DIM*ELEM_W-1:0]  matrix_a;
   logic [DIM*DIM*ELEM_W-1:0]  matrix_b;
   logic                       busy;
   logic                       done;
   logic [DIM*DIM*ELEM_W-1:0]  result;
   logic                       ovf;

   modport master (
      output start, sat_mode, matrix_a, matrix_b,
      input  busy, done, result, ovf
   );

   modport slave (
      input  start, sat_mode, matrix_a, matrix_b,
      output busy, done, result, ovf
   );
endinterface
`default_nettype wire

// File: rtl/matmul_mac.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matmul_mac : one multiply-add step plus wrap/saturate element conversion.
//              MATMUL_SIGNED_EN selects two's complement arithmetic.
// Rev 1.0    : initial release
// ----------------------------------------------------------------------------
module matmul_mac
   import matmul_pkg::*;
#(
   parameter  int ELEM_W = c_def_elem_w,
   parameter  int DIM    = c_def_dim,
   localparam int ACC_W  = acc_width(ELEM_W, DIM)
) (
   input  wire logic [ACC_W-1:0]  acc,
   input  wire logic [ELEM_W-1:0] a,
   input  wire logic [ELEM_W-1:0] b,
   input  wire logic              sat_mode,
   output logic      [ACC_W-1:0]  acc_next,
   output logic      [ELEM_W-1:0] elem,
   output logic                   elem_ovf
);
`ifdef MATMUL_SIGNED_EN
   localparam logic signed [ACC_W-1:0] c_smax = ACC_W'((1 << (ELEM_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] c_smin = -c_smax - ACC_W'(1);

   logic signed [2*ELEM_W-1:0] w_prod;
   logic                       w_hi;
   logic                       w_lo;

   always_comb begin
      w_prod   = $signed(a) * $signed(b);
      acc_next = acc + ACC_W'(w_prod);
      w_hi     = $signed(acc_next) > c_smax;
      w_lo     = $signed(acc_next) < c_smin;
      elem_ovf = w_hi | w_lo;
      elem     = acc_next[ELEM_W-1:0];
      if (sat_mode && w_hi) begin
         elem = {1'b0, {(ELEM_W-1){1'b1}}};
      end else if (sat_mode && w_lo) begin
         elem = {1'b1, {(ELEM_W-1){1'b0}}};
      end
   end
`else
   localparam logic [ACC_W-1:0] c_umax = ACC_W'((1 << ELEM_W) - 1);

   logic [2*ELEM_W-1:0] w_prod;

   always_comb begin
      w_prod   = a * b;
      acc_next = acc + ACC_W'(w_prod);
      elem_ovf = acc_next > c_umax;
      elem     = acc_next[ELEM_W-1:0];
      if (sat_mode && elem_ovf) begin
         elem = '1;
      end
   end
`endif
endmodule
`default_nettype wire

// File: rtl/matmul_seq_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matmul_seq_unit : sequential DIM x DIM matrix multiplier, one MAC per clock.
//                   Optional macro MATMUL_SIGNED_EN selects signed elements.
// Rev 1.0         : initial release
// ----------------------------------------------------------------------------
module matmul_seq_unit
   import matmul_pkg::*;
#(
   parameter int ELEM_W = c_def_elem_w,
   parameter int DIM    = c_def_dim
) (
   input  wire logic        clk,
   input  wire logic        rst,
   matmul_seq_unit_if.slave bus
);
   localparam int ACC_W    = acc_width(ELEM_W, DIM);
   localparam int c_idx_w  = $clog2(DIM);
   localparam int c_flat_w = DIM * DIM * ELEM_W;
   localparam logic [c_idx_w-1:0] c_last = c_idx_w'(DIM - 1);

   state_t               r_state;
   state_t               w_state_next;
   logic [c_flat_w-1:0]  r_a;
   logic [c_flat_w-1:0]  r_b;
   logic [c_flat_w-1:0]  r_buf;
   logic [c_flat_w-1:0]  r_result;
   logic                 r_sat;
   logic [c_idx_w-1:0]   r_i;
   logic [c_idx_w-1:0]   r_j;
   logic [c_idx_w-1:0]   r_k;
   logic [ACC_W-1:0]     r_acc;
   logic                 r_ovf_sticky;
   logic                 r_ovf;
   logic                 r_done;

   logic [ELEM_W-1:0]    w_a_elem;
   logic [ELEM_W-1:0]    w_b_elem;
   logic [ACC_W-1:0]     w_acc_next;
   logic [ELEM_W-1:0]    w_elem;
   logic                 w_elem_ovf;

   always_comb begin
      w_a_elem = r_a[ELEM_W * (int'(r_i) * DIM + int'(r_k)) +: ELEM_W];
      w_b_elem = r_b[ELEM_W * (int'(r_k) * DIM + int'(r_j)) +: ELEM_W];
   end

   matmul_mac #(
      .ELEM_W (ELEM_W),
      .DIM    (DIM)
   ) u_mac (
      .acc      (r_acc),
      .a        (w_a_elem),
      .b        (w_b_elem),
      .sat_mode (r_sat),
      .acc_next (w_acc_next),
      .elem     (w_elem),
      .elem_ovf (w_elem_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (bus.start) w_state_next = ST_LOAD;
         ST_LOAD:  w_state_next = ST_CALC;
         ST_CALC:  if (r_i == c_last && r_j == c_last && r_k == c_last)
                      w_state_next = ST_STORE;
         ST_STORE: w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a          <= '0;
         r_b          <= '0;
         r_sat        <= 1'b0;
         r_buf        <= '0;
         r_result     <= '0;
         r_i          <= '0;
         r_j          <= '0;
         r_k          <= '0;
         r_acc        <= '0;
         r_ovf_sticky <= 1'b0;
         r_ovf        <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_a   <= bus.matrix_a;
                  r_b   <= bus.matrix_b;
                  r_sat <= bus.sat_mode;
               end
            end
            ST_LOAD: begin
               r_i          <= '0;
               r_j          <= '0;
               r_k          <= '0;
               r_acc        <= '0;
               r_ovf_sticky <= 1'b0;
            end
            ST_CALC: begin
               if (r_k == c_last) begin
                  // Last product of a dot product: retire the element.
                  r_buf[ELEM_W * (int'(r_i) * DIM + int'(r_j)) +: ELEM_W] <= w_elem;
                  r_ovf_sticky <= r_ovf_sticky | w_elem_ovf;
                  r_acc        <= '0;
                  r_k          <= '0;
                  if (r_j == c_last) begin
                     r_j <= '0;
                     r_i <= (r_i == c_last) ? '0 : r_i + 1'b1;
                  end else begin
                     r_j <= r_j + 1'b1;
                  end
               end else begin
                  r_acc <= w_acc_next;
                  r_k   <= r_k + 1'b1;
               end
            end
            ST_STORE: begin
               r_result <= r_buf;
               r_ovf    <= r_ovf_sticky;
               r_done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = (r_state != ST_IDLE);
   assign bus.done   = r_done;
   assign bus.result = r_result;
   assign bus.ovf    = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_matmul_seq_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_matmul_seq_unit : vector table, random ops against an arithmetic model,
//                      and handshake corner sequences for matmul_seq_unit.
// Rev 1.0            : initial release
// ----------------------------------------------------------------------------
module tb_matmul_seq_unit;
   localparam int ELEM_W  = 4;
   localparam int DIM     = 4;
   localparam int N       = DIM * DIM * ELEM_W;
   localparam int LATENCY = DIM * DIM * DIM + 3;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         sat;
      logic [N-1:0] exp_res;
      logic         exp_ovf;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   matmul_seq_unit_if #(.ELEM_W(ELEM_W), .DIM(DIM)) bus ();

   matmul_seq_unit #(.ELEM_W(ELEM_W), .DIM(DIM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic int elem_val(input logic [N-1:0] m, input int r, input int c);
      logic [ELEM_W-1:0] e;
      e = m[ELEM_W * (r * DIM + c) +: ELEM_W];
`ifdef MATMUL_SIGNED_EN
      return int'($signed(e));
`else
      return int'(e);
`endif
   endfunction

   // Plain integer dot products, then clamp or truncate each element.
   function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sat,
                                 output logic [N-1:0] res, output logic ov);
      int lo, hi, sum;
      logic [31:0] v;
`ifdef MATMUL_SIGNED_EN
      lo = -(1 << (ELEM_W - 1));
      hi = (1 << (ELEM_W - 1)) - 1;
`else
      lo = 0;
      hi = (1 << ELEM_W) - 1;
`endif
      res = '0;
      ov  = 1'b0;
      for (int r = 0; r < DIM; r++) begin
         for (int c = 0; c < DIM; c++) begin
            sum = 0;
            for (int k = 0; k < DIM; k++) sum += elem_val(a, r, k) * elem_val(b, k, c);
            if (sum > hi || sum < lo) ov = 1'b1;
            if (sat && sum > hi)      v = hi;
            else if (sat && sum < lo) v = lo;
            else                      v = sum;
            res[ELEM_W * (r * DIM + c) +: ELEM_W] = v[ELEM_W-1:0];
         end
      end
   endfunction

   // Called at a negedge; the next rising edge samples the request.
   task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sat);
      bus.matrix_a = a;
      bus.matrix_b = b;
      bus.sat_mode = sat;
      bus.start    = 1'b1;
   endtask

   // Operands are scrambled right after acceptance to prove they were captured.
   task automatic wait_done(output logic [N-1:0] res, output logic ov, output int lat);
      lat = 0;
      res = '0;
      ov  = 1'b0;
      while (lat < 300) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat == 1) begin
            bus.start    = 1'b0;
            bus.matrix_a = {$urandom, $urandom};
            bus.matrix_b = {$urandom, $urandom};
            bus.sat_mode = 1'($urandom);
         end
         if (bus.done) begin
            res = bus.result;
            ov  = bus.ovf;
            return;
         end
      end
      check("done_timeout", 64'd0, 64'd1);
   endtask

   vec_t         tbl[4];
   logic [N-1:0] res;
   logic [N-1:0] exp_res;
   logic         ov;
   logic         exp_ov;
   logic [N-1:0] ra;
   logic [N-1:0] rb;
   logic         rs;
   int           lat;
   int           n_done;
   int           first_done;

   initial begin
      checks   = 0;
      failures = 0;
`ifdef MATMUL_SIGNED_EN
      tbl[0] = '{64'h1000010000100001, 64'hFEDCBA9876543210, 1'b0, 64'hFEDCBA9876543210, 1'b0};
      tbl[1] = '{64'hFFFFFFFFFFFFFFFF, 64'h1111111111111111, 1'b0, 64'hCCCCCCCCCCCCCCCC, 1'b0};
      tbl[2] = '{64'h8888888888888888, 64'h8888888888888888, 1'b1, 64'h7777777777777777, 1'b1};
      tbl[3] = '{64'h8888888888888888, 64'h8888888888888888, 1'b0, 64'h0000000000000000, 1'b1};
`else
      tbl[0] = '{64'h1000010000100001, 64'hFEDCBA9876543210, 1'b0, 64'hFEDCBA9876543210, 1'b0};
      tbl[1] = '{64'h1111111111111111, 64'h1111111111111111, 1'b0, 64'h4444444444444444, 1'b0};
      tbl[2] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h4444444444444444, 1'b1};
      tbl[3] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1};
`endif
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.sat_mode = 1'b0;
      bus.matrix_a = '0;
      bus.matrix_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_busy",   64'(bus.busy), 64'd0);
      check("reset_done",   64'(bus.done), 64'd0);
      check("reset_result", bus.result,    64'd0);
      check("reset_ovf",    64'(bus.ovf),  64'd0);

      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         start_op(tbl[t].a, tbl[t].b, tbl[t].sat);
         wait_done(res, ov, lat);
         check($sformatf("tbl%0d_result", t),  res,     tbl[t].exp_res);
         check($sformatf("tbl%0d_ovf", t),     64'(ov), 64'(tbl[t].exp_ovf));
         check($sformatf("tbl%0d_latency", t), 64'(lat), 64'(LATENCY));
         @(negedge clk);
         check($sformatf("tbl%0d_done_pulse", t), 64'(bus.done), 64'd0);
      end

      for (int t = 0; t < 12; t++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rs = 1'($urandom);
         model(ra, rb, rs, exp_res, exp_ov);
         @(negedge clk);
         start_op(ra, rb, rs);
         wait_done(res, ov, lat);
         check($sformatf("rand%0d_result", t), res,     exp_res);
         check($sformatf("rand%0d_ovf", t),    64'(ov), 64'(exp_ov));
      end

      // Extra start pulses while busy must be dropped.
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      model(ra, rb, 1'b0, exp_res, exp_ov);
      @(negedge clk);
      start_op(ra, rb, 1'b0);
      n_done     = 0;
      first_done = 0;
      for (int cyc = 1; cyc <= 150; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         bus.start = 1'b0;
         if (cyc == 5 || cyc == 30) begin
            start_op(~ra, ~rb, 1'b1);
         end
         if (bus.done) begin
            n_done++;
            if (first_done == 0) begin
               first_done = cyc;
               res = bus.result;
               ov  = bus.ovf;
            end
         end
      end
      check("busy_start_done_count", 64'(n_done),     64'd1);
      check("busy_start_latency",    64'(first_done), 64'(LATENCY));
      check("busy_start_result",     res,             exp_res);
      check("busy_start_ovf",        64'(ov),         64'(exp_ov));

      // Back-to-back: start issued in the done cycle is accepted.
      @(negedge clk);
      start_op(tbl[3].a, tbl[3].b, tbl[3].sat);
      wait_done(res, ov, lat);
      start_op(tbl[1].a, tbl[1].b, tbl[1].sat);
      wait_done(res, ov, lat);
      check("b2b_latency", 64'(lat), 64'(LATENCY));
      check("b2b_result",  res,      tbl[1].exp_res);
      check("b2b_ovf",     64'(ov),  64'(tbl[1].exp_ovf));

      // Reset mid-CALC after a result with ovf set.
      @(negedge clk);
      start_op(tbl[2].a, tbl[2].b, tbl[2].sat);
      wait_done(res, ov, lat);
      @(negedge clk);
      start_op(tbl[1].a, tbl[1].b, 1'b0);
      repeat (20) begin
         @(posedge clk);
         @(negedge clk);
         bus.start = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy",   64'(bus.busy), 64'd0);
      check("midrst_done",   64'(bus.done), 64'd0);
      check("midrst_result", bus.result,    64'd0);
      check("midrst_ovf",    64'(bus.ovf),  64'd0);
      n_done = 0;
      repeat (80) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done) n_done++;
      end
      check("midrst_no_done", 64'(n_done), 64'd0);
      start_op(tbl[0].a, tbl[0].b, tbl[0].sat);
      wait_done(res, ov, lat);
      check("after_rst_latency", 64'(lat), 64'(LATENCY));
      check("after_rst_result",  res,      tbl[0].exp_res);
      check("after_rst_ovf",     64'(ov),  64'(tbl[0].exp_ovf));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/matmul_seq_unit.md
Name: matmul_seq_unit

Overview:
- Parametrised sequential square-matrix multiplier: RESULT = A x B for DIM x DIM matrices of ELEM_W-bit elements.
- Performs one multiply-accumulate per clock.
- Adds a start/busy/done handshake, operand capture, a selectable saturate/wrap output stage and an overflow flag.
- Sits behind the accelerator register interface as the next-generation matrix engine; the caller may change matrix_a/matrix_b while busy.

Parameters:
- ELEM_W, 4, element width in bits (>=2).
- DIM, 4, matrix dimension (>=2); element (r,c) sits at flat index ELEM_W*(r*DIM+c).
- ACC_W, 2*ELEM_W+$clog2(DIM), localparam; accumulator width, never overflows.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- sat_mode  in  1  1 = saturate result elements, 0 = keep low ELEM_W bits (wrap). Sampled with the operands.
- matrix_a  in  DIM*DIM*ELEM_W  left operand, row-major flat.
- matrix_b  in  DIM*DIM*ELEM_W  right operand, row-major flat.
- busy  out  1  high in LOAD/CALC/STORE.
- done  out  1  one-cycle pulse; result and ovf are valid from this cycle on.
- result  out  DIM*DIM*ELEM_W  product, row-major flat; holds until the next STORE.
- ovf  out  1  any element of the last result exceeded the ELEM_W range; updated with result.

Behaviour:
- Reset: the following clear to zero:
  - outputs busy, done, result, ovf;
  - internal registers i, j, k, accumulator and the result buffer.
  - State goes to IDLE. Reset wins over every other event, including mid-CALC; a partial result is never published.
- IDLE:
  - On start=1, capture matrix_a, matrix_b and sat_mode into internal registers, then go to LOAD.
  - If start=0, stay in IDLE.
- LOAD: one cycle. Clear i, j, k and the accumulator, then go to CALC.
- CALC:
  - Each cycle, acc_next = acc + A[i][k]*B[k][j]; k increments.
  - When k = DIM-1, convert acc_next to an element and write it to buffer[i][j]. Then clear acc and k, and advance j; at j wrap, advance i.
  - After the element (DIM-1, DIM-1) is written, go to STORE.
  - CALC lasts exactly DIM^3 cycles.
- STORE:
  - Copy the buffer to result, set ovf from the sticky per-operation overflow bit and pulse done.
  - Then go to IDLE.
- Latency: if start is sampled high at cycle t, done=1 in cycle t+DIM^3+3 (67 cycles for DIM=4).
- start while busy is ignored; there is no queueing.
- start in the same cycle that done=1 is accepted, because the state is already IDLE. done is not re-pulsed until that operation completes.
- Output conversion (unsigned):
  - Wrap: element = acc[ELEM_W-1:0].
  - Saturate: element = min(acc, 2^ELEM_W-1).
- Overflow bit: set for the operation whenever acc > 2^ELEM_W-1, in both modes. It is cleared in LOAD.
- Operand stability: operands are needed only in the accepting cycle.

Optional Feature:
- MATMUL_SIGNED_EN defined:
  - Elements are two's complement and the accumulator is signed.
  - Saturate clamps to [-2^(ELEM_W-1), 2^(ELEM_W-1)-1]; wrap keeps the low ELEM_W bits.
  - ovf is set when acc falls outside the signed range.
- MATMUL_SIGNED_EN undefined: unsigned arithmetic as described above.
- Port list is identical in both builds.

Decomposition:
- Package matmul_pkg:
  - state enum type (IDLE, LOAD, CALC, STORE), 2 bits;
  - default ELEM_W/DIM constants;
  - function computing ACC_W.
- Sub-module matmul_mac:
  - combinational multiply-add of one product into the accumulator;
  - output conversion (wrap/saturate, signed per macro);
  - per-element overflow flag.

Test Plan:
- A = identity, B = 0xFEDCBA9876543210 (DIM=4, ELEM_W=4), sat_mode=0 -> result = B, ovf=0, done exactly 67 cycles after start.
- A and B all elements 1 -> every element 4, result 0x4444444444444444, ovf=0.
- A and B all elements 15 (acc=900 per element):
  - sat_mode=0 -> every element 4, ovf=1;
  - sat_mode=1 -> result all 0xF, ovf=1.
- Pulse start again at cycles 5 and 30 after the first start, with different operands -> ignored; done is a single pulse at cycle 67 and result reflects the first operands.
- Assert rst for one cycle during CALC -> next cycle busy=0, result=0, ovf=0. A new start then completes normally in 67 cycles.
- MATMUL_SIGNED_EN, A all 0xF (-1), B all 1 -> elements -4 (0xC), ovf=0. Then A and B all 0x8 (-8), acc=256:
  - sat_mode=1 -> elements 0x7, ovf=1;
  - sat_mode=0 -> elements 0x0, ovf=1.
